// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings and FSM states for the iterative multiply/divide unit
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/iterative_muldiv_unit_if.sv
// rtl/iterative_muldiv_unit_if.sv - request/result bundle between controller and multiply/divide unit
interface iterative_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, divzero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, divzero, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Divide keeps {remainder, dividend/quotient}; multiply keeps {partial, multiplier}.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    borrow = rem_sh < {1'b0, opnd_i};
    diff   = rem_sh[WIDTH-1:0] - opnd_i;
    if (is_div) begin
      if (borrow) acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      else        acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/iterative_muldiv_unit.sv
// rtl/iterative_muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU with HI/LO result registers
module iterative_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  iterative_muldiv_unit_if.slave  bus
);
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 dz_pend_q, dz_pend_d;
  logic                 divz_q, divz_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 sgn, dz, a_neg, b_neg;
  logic [2*WIDTH-1:0]   prod_neg;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      dz_pend_q <= dz_pend_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = CALC;
      CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divide-by-zero runs on the raw dividend so the iterations leave lo=all ones, hi=a.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    dz_pend_d = dz_pend_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sgn       = bus.op[0];
    dz        = bus.op[1] && (bus.b == '0);
    a_neg     = sgn && bus.a[WIDTH-1] && !dz;
    b_neg     = sgn && bus.b[WIDTH-1];
    prod_neg  = -acc_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        cnt_d     = '0;
        is_div_d  = bus.op[1];
        acc_d     = {{WIDTH{1'b0}}, (a_neg ? -bus.a : bus.a)};
        opnd_d    = b_neg ? -bus.b : bus.b;
        neg_lo_d  = a_neg ^ b_neg;
        neg_hi_d  = bus.op[1] ? a_neg : (a_neg ^ b_neg);
        dz_pend_d = dz;
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
      end
      FIX: begin
        divz_d = dz_pend_q;
        if (is_div_q) begin
          hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        end else begin
          hi_d = neg_lo_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = neg_lo_q ? prod_neg[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
    bus.divzero = divz_q;
    bus.hi      = hi_q;
    bus.lo      = lo_q;
  end
endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// tb/tb_iterative_muldiv_unit.sv - vector table, random reference-model and corner sequences for the muldiv unit
module tb_iterative_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  iterative_muldiv_unit_if #(.WIDTH(W)) bus ();
  iterative_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV / and % truncate toward zero.
  function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'b01: begin p = sa * sb; return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[W-1:0], q[W-1:0]};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit busy_ok, output bit post_ok);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
    busy_ok = 1'b1;
    lat = 999;
    for (n = 1; n <= 100; n++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin lat = n; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    post_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    int lat, dones;
    bit busy_ok, post_ok;
    logic [2*W:0] exp;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1] = '{2'b01, -32'sd3,      32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{2'b11, -32'sd7,      32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4] = '{2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_divzero", bus.divzero, 0);
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_ok, post_ok);
      chk($sformatf("vec%0d_latency", i), lat, W + 2);
      chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
      chk($sformatf("vec%0d_divzero", i), bus.divzero, vecs[i].dz);
      chk($sformatf("vec%0d_busy", i), busy_ok, 1);
      chk($sformatf("vec%0d_single_done", i), post_ok, 1);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = (i % 4 == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      case (i % 5)
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 17));
        2:       rb = -W'($urandom_range(1, 17));
        default: rb = W'($urandom);
      endcase
      exp = model(rop, ra, rb);
      run_op(rop, ra, rb, lat, busy_ok, post_ok);
      chk($sformatf("rnd%0d_op%0d_result", i, rop), {bus.divzero, bus.hi, bus.lo}, 64'(exp[2*W-1:0]) | 64'(0));
      chk($sformatf("rnd%0d_divzero", i), bus.divzero, exp[2*W]);
      chk($sformatf("rnd%0d_latency", i), lat, W + 2);
    end

    // Start while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    lat = 999;
    for (int n = 1; n <= 60; n++) begin
      if (n == 10) begin bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd9; bus.b = 32'd3; end
      else bus.start = 1'b0;
      if (bus.done === 1'b1) begin dones++; if (lat == 999) lat = n; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("ignore_done_count", dones, 1);
    chk("ignore_latency", lat, W + 2);
    chk("ignore_lo", bus.lo, 25);
    chk("ignore_hi", bus.hi, 0);

    // Reset mid-operation abandons the op.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = -32'sd3; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (13) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_hi", bus.hi, 0);
    chk("midreset_lo", bus.lo, 0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    chk("midreset_no_done", dones, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iterative_muldiv_unit.md
Name: iterative_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit; successor to the single-cycle combinational ALU.
- Parametrised in operand width.
- Runs MIPS-style MULT/MULTU/DIV/DIVU over several cycles and writes results into internal HI/LO registers.
- Sits beside the ALU in the execute stage; the controller stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when hi/lo are updated.
- divzero  out  1  valid with done: divide op had b==0.
- hi  out  WIDTH  multiply: upper product half; divide: remainder.
- lo  out  WIDTH  multiply: lower product half; divide: quotient.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, divzero=0, hi=0, lo=0.
- Reset has priority over everything, including mid-operation: the operation is abandoned and no done pulse is issued.
- States and transitions:
  - IDLE: start=1 at edge k → latch op and magnitude operands (|a|, |b| for signed ops; raw values for unsigned), record result signs, counter=0 → CALC.
  - CALC: one iteration per cycle, counter+1. After the WIDTH-th iteration → FIX.
  - FIX: apply signs (two's-complement negate) → DONE.
  - DONE: hi/lo written, done=1 for exactly one cycle → IDLE.
- Latency: start accepted at edge k → done=1 during cycle k+WIDTH+2, i.e. WIDTH+2 cycles after acceptance. Back-to-back start is accepted in the cycle after done.
- busy=1 in CALC, FIX and DONE; busy=0 in IDLE.
- start while busy is ignored; it is neither queued nor affects the running op.
- op, a and b are don't-care except when sampled with start.
- Multiply: shift-add over a 2·WIDTH accumulator. Signed product = sign(a) XOR sign(b) applied to the 2·WIDTH magnitude.
- Divide: restoring shift-subtract.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - |remainder| < |divisor|.
- Divide by zero: divzero=1 with done; lo=all ones, hi=a as sampled. Same for DIV and DIVU, with no sign fix.
- Signed overflow (DIV MIN/−1): lo=MIN, hi=0, divzero=0.
- hi/lo hold their values between operations. divzero holds until the next done.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV
  - state enum IDLE/CALC/FIX/DONE
- Sub-module muldiv_step: combinational, one iteration; inputs op class, accumulator, operand; output next accumulator. The top holds the FSM, counter and registers.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=2 → done at cycle 34 after acceptance; hi=0x00000001, lo=0xFFFFFFFE, busy=1 for cycles 1..34.
- MULT a=−3, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=100, b=0 → divzero=1, lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0, divzero=0.
- Start MULTU 5×5, then pulse start with DIVU 9/3 at cycle 10 → ignored; done once with lo=25, hi=0.
- Start MULT, assert reset at cycle 15 → next cycle busy=0, hi=lo=0, and no done pulse in the next 40 cycles.
